// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid/ready handshake on both sides.
// Define MEMWB_SKID_EN to add a skid entry so in_ready depends only on the state register.
module mem_wb_stage #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] read_data,
  input  logic             mem_to_reg,
  input  logic [AW-1:0]    rd,
  input  logic             reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] wb_d0,
  output logic [WIDTH-1:0] wb_d1,
  output logic             wb_sel,
  output logic [AW-1:0]    wb_rd,
  output logic             wb_reg_write,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] rdata;
    logic             sel;
    logic [AW-1:0]    rd;
    logic             rw;
  } entry_t;

`ifdef MEMWB_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1} state_t;
`endif

  state_t state;
  entry_t in_entry;
  entry_t main_p0;
`ifdef MEMWB_SKID_EN
  entry_t skid_p0;
`endif
  logic   in_fire;
  logic   out_fire;

  assign in_entry  = {alu_result, read_data, mem_to_reg, rd, reg_write};
  assign out_valid = (state != EMPTY);
`ifdef MEMWB_SKID_EN
  assign in_ready  = (state != FULL);
`else
  assign in_ready  = !out_valid | out_ready;
`endif
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Stage boundary: head (main) and skid registers; flush discards any same-cycle input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      main_p0 <= '0;
`ifdef MEMWB_SKID_EN
      skid_p0 <= '0;
`endif
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_p0 <= in_entry;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_p0 <= in_entry;
`ifdef MEMWB_SKID_EN
          end else if (in_fire) begin
            skid_p0 <= in_entry;
            state   <= FULL;
`endif
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
`ifdef MEMWB_SKID_EN
        FULL: begin
          if (out_ready) begin
            main_p0 <= skid_p0;
            state   <= BUSY;
          end
        end
`endif
        default: state <= EMPTY;
      endcase
    end
  end

  assign wb_d0        = main_p0.alu;
  assign wb_d1        = main_p0.rdata;
  assign wb_sel       = main_p0.sel;
  assign wb_rd        = main_p0.rd;
  assign wb_reg_write = main_p0.rw & out_valid;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      BUSY:    occupancy = 2'd1;
`ifdef MEMWB_SKID_EN
      FULL:    occupancy = 2'd2;
`endif
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a FIFO model of held entries checked every cycle.
module tb_mem_wb_stage;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] read_data;
  logic             mem_to_reg;
  logic [AW-1:0]    rd;
  logic             reg_write;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] wb_d0;
  logic [WIDTH-1:0] wb_d1;
  logic             wb_sel;
  logic [AW-1:0]    wb_rd;
  logic             wb_reg_write;
  logic [1:0]       occupancy;

  mem_wb_stage #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .read_data(read_data), .mem_to_reg(mem_to_reg),
    .rd(rd), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_d0(wb_d0), .wb_d1(wb_d1), .wb_sel(wb_sel), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] rdata;
    logic             sel;
    logic [AW-1:0]    rd;
    logic             rw;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
`ifdef MEMWB_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model, then apply this cycle's transfers to it.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_wb_d0", {24'd0, wb_d0}, 32'd0);
      chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
      chk("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      q.delete();
    end else begin
      logic exp_ir;
      if (CAP == 2) exp_ir = (q.size() < 2);
      else          exp_ir = (q.size() == 0) || out_ready;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("occupancy", {30'd0, occupancy}, q.size());
      if (q.size() > 0) begin
        chk("wb_d0", {24'd0, wb_d0}, {24'd0, q[0].alu});
        chk("wb_d1", {24'd0, wb_d1}, {24'd0, q[0].rdata});
        chk("wb_sel", {31'd0, wb_sel}, {31'd0, q[0].sel});
        chk("wb_rd", {28'd0, wb_rd}, {28'd0, q[0].rd});
        chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, q[0].rw});
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("wb_reg_write_idle", {31'd0, wb_reg_write}, 32'd0);
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        exp_t e;
        e.alu = alu_result; e.rdata = read_data; e.sel = mem_to_reg;
        e.rd = rd; e.rw = reg_write;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an entry and hold it until the cycle it is accepted (bounded).
  task automatic send(input logic [7:0] a, input logic [7:0] d, input logic s,
                      input logic [3:0] r, input logic w);
    logic ok;
    int   n;
    alu_result = a; read_data = d; mem_to_reg = s; rd = r; reg_write = w;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout actual=stalled required=accepted at %0t", $time);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    alu_result = 8'hAA; read_data = 8'h55; mem_to_reg = 1'b0; rd = 4'h7; reg_write = 1'b1;
    step(); step();
    reset = 1'b1; idle();
    step();

    // Single pass
    out_ready = 1'b1;
    send(8'h15, 8'h40, 1'b1, 4'd3, 1'b1);
    idle(); step(); step();

    // Stall and skid
    out_ready = 1'b0;
    send(8'h95, 8'h01, 1'b0, 4'd5, 1'b1);
`ifdef MEMWB_SKID_EN
    send(8'h3C, 8'h02, 1'b1, 4'd6, 1'b0);
    idle(); step(); step();
    out_ready = 1'b1;
`else
    alu_result = 8'h3C; read_data = 8'h02; mem_to_reg = 1'b1; rd = 4'd6; reg_write = 1'b0;
    in_valid = 1'b1;
    step(); step(); step();
    out_ready = 1'b1;
    send(8'h3C, 8'h02, 1'b1, 4'd6, 1'b0);
`endif
    idle(); step(); step(); step();

    // Streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 8'(8'h80 + i), i[0], 4'(i), i[1]);
    idle(); step(); step();

    // Flush with a same-cycle input, from the deepest state and from BUSY
    out_ready = 1'b0;
    send(8'h11, 8'h12, 1'b0, 4'd1, 1'b1);
`ifdef MEMWB_SKID_EN
    send(8'h21, 8'h22, 1'b1, 4'd2, 1'b1);
`endif
    alu_result = 8'hC0; read_data = 8'hC0; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; idle(); step(); step();
    send(8'h31, 8'h32, 1'b0, 4'd4, 1'b1);
    alu_result = 8'hC0; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; idle(); out_ready = 1'b1; step(); step();

    // Randomized traffic with occasional flush and an asynchronous reset pulse
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 1) == 1);
      alu_result = 8'($urandom);
      read_data  = 8'($urandom);
      mem_to_reg = 1'($urandom);
      rd         = 4'($urandom);
      reg_write  = 1'($urandom);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 29) == 0);
      if (i == 200) begin
        #2 reset = 1'b0;
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end

    flush = 1'b0; idle(); out_ready = 1'b1;
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
